// File: rtl/sort_pkg.sv
// sort_pkg: shared widths and loader state encoding for the bubble-sort slice.
package sort_pkg;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, START, ARM, WAIT} loader_state_t;
endpackage

// File: rtl/sort_loader.sv
// sort_loader: streams a byte list into sort memory and hands it to the sorter.
module sort_loader
  import sort_pkg::*;
(
  input  logic          t_clk,
  input  logic          t_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_own,
  output logic          sort_go,
  output logic [AW:0]   sort_n,
  input  logic          sort_done,
  output logic          overflow
);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  loader_state_t state, nxt;
  logic [AW:0] cnt;
  logic acc, wr;
  always_comb begin
    acc = in_valid & in_ready;
    wr = acc && state != DRAIN;
    nxt = state;
    case (state)
      IDLE, LOAD: if (acc) nxt = in_last ? FLUSH : (cnt == LAST) ? DRAIN : LOAD;
      DRAIN:      if (acc && in_last) nxt = FLUSH;
      FLUSH:      nxt = START;
      START:      nxt = ARM;
      ARM:        if (!sort_done) nxt = WAIT;
      WAIT:       if (sort_done) nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_own <= 1'b1;
      sort_go <= 1'b0;
      sort_n <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      in_ready <= nxt inside {IDLE, LOAD, DRAIN};
      mem_own <= nxt inside {IDLE, LOAD, DRAIN, FLUSH};
      sort_go <= nxt == START;
      mem_we <= wr;
      if (wr) begin
        mem_addr <= cnt[AW-1:0];
        mem_wdata <= in_data;
        cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
      end
      if (wr && state == IDLE) overflow <= 1'b0;
      if (wr && !in_last && cnt == LAST) overflow <= 1'b1;
      if (nxt == START) sort_n <= cnt;
      if (state == WAIT && sort_done) cnt <= '0;
    end
  end
endmodule
